// File: rtl/serial_cascade_comparator_if.sv
// Handshake bundle for the serial cascade comparator: operand/seed input channel,
// result output channel and progress status.
interface serial_cascade_comparator_if #(
    parameter int WIDTH = 9
);
    localparam int NSLICE = WIDTH / 3;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cas_l;
    logic             cas_e;
    logic             cas_g;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             et;
    logic             gt;
    logic             busy;
    logic [IDXW-1:0]  slice_idx;

    modport master (
        output in_valid, a, b, cas_l, cas_e, cas_g, out_ready,
        input  in_ready, out_valid, lt, et, gt, busy, slice_idx
    );

    modport slave (
        input  in_valid, a, b, cas_l, cas_e, cas_g, out_ready,
        output in_ready, out_valid, lt, et, gt, busy, slice_idx
    );
endinterface

// File: rtl/serial_cascade_comparator.sv
// Multi-cycle unsigned magnitude comparator: one 3-bit slice per clock, LSB first,
// with the registered slice result fed back as the cascade input of the next slice.
module serial_cascade_comparator #(
    parameter int WIDTH = 9
) (
    input logic                     clk,
    input logic                     rst,
    serial_cascade_comparator_if.slave bus
);
    localparam int NSLICE = WIDTH / 3;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       res_r;
    logic [IDXW-1:0]  slice_idx_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             out_valid_r;
    logic             lt_r;
    logic             et_r;
    logic             gt_r;
    logic [2:0]       res_next_s;

    // One 3-bit comparator stage: a differing slice overrides the cascade, equal passes it on.
    function automatic logic [2:0] slice_cmp(input logic [2:0] sa, input logic [2:0] sb,
                                             input logic [2:0] casc);
        logic [2:0] r;
        if (sa > sb) begin
            r = 3'b001;
        end else if (sa < sb) begin
            r = 3'b100;
        end else begin
            r = casc;
        end
        return r;
    endfunction

    // Operands are shifted right each RUN cycle, so the active slice always sits in bits [2:0].
    always_comb begin
        res_next_s = slice_cmp(a_r[2:0], b_r[2:0], res_r);
    end

    // Control FSM, operand shifters, cascade register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            res_r       <= 3'b000;
            slice_idx_r <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            lt_r        <= 1'b0;
            et_r        <= 1'b0;
            gt_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r         <= bus.a;
                        b_r         <= bus.b;
                        res_r       <= {bus.cas_l, bus.cas_e, bus.cas_g};
                        slice_idx_r <= '0;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r   <= a_r >> 3'd3;
                    b_r   <= b_r >> 3'd3;
                    res_r <= res_next_s;
                    if (slice_idx_r == LAST_IDX) begin
                        slice_idx_r <= '0;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        lt_r        <= res_next_s[2];
                        et_r        <= res_next_s[1];
                        gt_r        <= res_next_s[0];
                        state_r     <= ST_DONE;
                    end else begin
                        slice_idx_r <= slice_idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    slice_idx_r <= '0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.lt        = lt_r;
    assign bus.et        = et_r;
    assign bus.gt        = gt_r;
    assign bus.slice_idx = slice_idx_r;
endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Self-checking bench: directed cases on a 9-bit instance plus randomized streaming on a
// 12-bit instance, both checked against a whole-operand compare model.
module tb_serial_cascade_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_cascade_comparator_if #(.WIDTH(9))  bus9 ();
    serial_cascade_comparator_if #(.WIDTH(12)) bus12 ();

    serial_cascade_comparator #(.WIDTH(9))  dut9  (.clk(clk), .rst(rst), .bus(bus9.slave));
    serial_cascade_comparator #(.WIDTH(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int res12_cnt = 0;
    logic [2:0] exp9_q[$];
    logic [2:0] exp12_q[$];
    int acc9_q[$];
    int acc12_q[$];
    logic seen9 = 1'b0;
    logic seen12 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Whole-operand reference: the seed survives only when the operands are equal.
    function automatic logic [2:0] ref_cmp(input logic [11:0] av, input logic [11:0] bv,
                                           input logic [2:0] seed);
        if (av < bv) return 3'b100;
        if (av > bv) return 3'b001;
        return seed;
    endfunction

    // Model: record an expectation for every accepted pair, retire it on output handshake.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp9_q.delete();  acc9_q.delete();
            exp12_q.delete(); acc12_q.delete();
        end else begin
            if (bus9.out_valid && bus9.out_ready && exp9_q.size() > 0) begin
                void'(exp9_q.pop_front()); void'(acc9_q.pop_front());
            end
            if (bus9.in_valid && bus9.in_ready) begin
                exp9_q.push_back(ref_cmp({3'b000, bus9.a}, {3'b000, bus9.b},
                                         {bus9.cas_l, bus9.cas_e, bus9.cas_g}));
                acc9_q.push_back(cyc);
            end
            if (bus12.out_valid && bus12.out_ready && exp12_q.size() > 0) begin
                void'(exp12_q.pop_front()); void'(acc12_q.pop_front());
                res12_cnt++;
            end
            if (bus12.in_valid && bus12.in_ready) begin
                exp12_q.push_back(ref_cmp(bus12.a, bus12.b,
                                          {bus12.cas_l, bus12.cas_e, bus12.cas_g}));
                acc12_q.push_back(cyc);
            end
        end
    end

    // Compare process: every cycle with out_valid high is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus9.out_valid) begin
                chk("ready_in_done9", bus9.in_ready, 1'b0);
                if (exp9_q.size() == 0) chk("spurious_valid9", bus9.out_valid, 1'b0);
                else begin
                    chk("result9", {bus9.lt, bus9.et, bus9.gt}, exp9_q[0]);
                    if (!seen9) chk("latency9", cyc - acc9_q[0], 3);
                end
            end
            if (bus12.out_valid) begin
                if (exp12_q.size() == 0) chk("spurious_valid12", bus12.out_valid, 1'b0);
                else begin
                    chk("result12", {bus12.lt, bus12.et, bus12.gt}, exp12_q[0]);
                    if (!seen12) chk("latency12", cyc - acc12_q[0], 4);
                end
            end
            if (bus9.busy) chk("ready_in_run9", bus9.in_ready, 1'b0);
        end
        seen9  = bus9.out_valid;
        seen12 = bus12.out_valid;
    end

    // Run one compare on the 9-bit instance, optionally stalling the consumer in DONE.
    task automatic do9(input logic [8:0] av, input logic [8:0] bv, input logic [2:0] seed,
                       input int hold, output logic [2:0] res);
        int n;
        chk("idle_ready9", bus9.in_ready, 1'b1);
        bus9.a = av; bus9.b = bv;
        {bus9.cas_l, bus9.cas_e, bus9.cas_g} = seed;
        bus9.in_valid = 1'b1;
        @(negedge clk);
        bus9.in_valid = 1'b0;
        bus9.a = 9'($urandom); bus9.b = 9'($urandom);
        {bus9.cas_l, bus9.cas_e, bus9.cas_g} = 3'($urandom);
        n = 0;
        while (!bus9.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_to_valid9", n, 3);
        res = {bus9.lt, bus9.et, bus9.gt};
        for (int i = 0; i < hold; i++) begin
            bus9.in_valid = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("stall_stable9", {bus9.lt, bus9.et, bus9.gt}, res);
            chk("stall_valid9", bus9.out_valid, 1'b1);
            chk("stall_busy9", bus9.busy, 1'b0);
        end
        bus9.in_valid = 1'b0;
        bus9.out_ready = 1'b1;
        @(negedge clk);
        bus9.out_ready = 1'b0;
        chk("drop_valid9", bus9.out_valid, 1'b0);
        chk("back_idle9", bus9.in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r;
        logic [8:0] ra, rb;
        logic [2:0] rs;
        bus9.in_valid = 1'b0; bus9.out_ready = 1'b0;
        bus9.a = '0; bus9.b = '0; bus9.cas_l = 1'b0; bus9.cas_e = 1'b1; bus9.cas_g = 1'b0;
        bus12.in_valid = 1'b0; bus12.out_ready = 1'b1;
        bus12.a = '0; bus12.b = '0; bus12.cas_l = 1'b0; bus12.cas_e = 1'b1; bus12.cas_g = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus9.out_valid, 1'b0);
        chk("rst_ltetgt", {bus9.lt, bus9.et, bus9.gt}, 3'b000);
        chk("rst_busy", bus9.busy, 1'b0);
        chk("rst_slice_idx", bus9.slice_idx, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus9.in_ready, 1'b1);

        do9(9'o525, 9'o525, 3'b010, 0, r); chk("equal_525", r, 3'b010);
        do9(9'o700, 9'o077, 3'b010, 0, r); chk("msb_wins", r, 3'b001);
        do9(9'o000, 9'o000, 3'b100, 0, r); chk("seed_100", r, 3'b100);
        do9(9'o000, 9'o000, 3'b101, 0, r); chk("seed_101", r, 3'b101);
        do9(9'o123, 9'o124, 3'b010, 5, r); chk("stall_lt", r, 3'b100);
        do9(9'o777, 9'o776, 3'b010, 0, r); chk("after_stall", r, 3'b001);

        // Reset in the middle of a compare; reset also wins over a simultaneous in_valid.
        bus9.a = 9'o456; bus9.b = 9'o123; bus9.in_valid = 1'b1;
        @(negedge clk);
        bus9.in_valid = 1'b0;
        chk("run_busy", bus9.busy, 1'b1);
        chk("run_idx0", bus9.slice_idx, 2'd0);
        @(negedge clk);
        chk("run_idx1", bus9.slice_idx, 2'd1);
        rst = 1'b1; bus9.in_valid = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus9.busy, 1'b0);
        chk("abort_valid", bus9.out_valid, 1'b0);
        chk("abort_ready", bus9.in_ready, 1'b1);
        chk("abort_idx", bus9.slice_idx, 2'd0);
        rst = 1'b0; bus9.in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_valid", bus9.out_valid, 1'b0);
        end

        for (int k = 0; k < 20; k++) begin
            ra = 9'($urandom);
            rb = (k % 3 == 0) ? ra : 9'($urandom);
            rs = 3'($urandom);
            do9(ra, rb, rs, k % 3, r);
            chk("rand9", r, ref_cmp({3'b000, ra}, {3'b000, rb}, rs));
        end

        // Streaming on the 12-bit instance with both handshakes held high.
        bus12.in_valid = 1'b1;
        for (int i = 0; i < 180; i++) begin
            bus12.a = 12'($urandom);
            bus12.b = (i % 4 == 0) ? bus12.a : 12'($urandom);
            {bus12.cas_l, bus12.cas_e, bus12.cas_g} = 3'($urandom);
            @(negedge clk);
        end
        bus12.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("stream_count12", (res12_cnt >= 25) ? 1 : 0, 1);
        chk("drain12", exp12_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
